// File: rtl/serial_scan_pkg.sv
// Shared encodings for the serial "11" scan controller and its detector core.
package serial_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } scan_state_e;

    // Detector states: B means the previous serial bit was 1.
    localparam logic DET_A = 1'b0;
    localparam logic DET_B = 1'b1;

endpackage

// File: rtl/pair_detect_core.sv
// Two-state Mealy "11" detector with synchronous clear and advance enable.
module pair_detect_core
    import serial_scan_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic w,
    output logic z
);

    logic state_q;
    logic state_d;

    always_comb begin
        state_d = state_q;
        if (clr)
            state_d = DET_A;
        else if (en)
            state_d = w ? DET_B : DET_A;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= DET_A;
        else
            state_q <= state_d;
    end

    assign z = w & (state_q == DET_B);

endmodule

// File: rtl/serial_pair_scan_ctrl.sv
// Shifts a captured word MSB-first through the "11" detector, counting
// overlapping matches and the index of the first one; pulses done at the end.
module serial_pair_scan_ctrl
    import serial_scan_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             busy,
    output logic             w,
    output logic             z,
    output logic             done,
    output logic             found,
    output logic [CNT_W-1:0] match_count,
    output logic [CNT_W-1:0] first_pos
);

    scan_state_e      state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CNT_W-1:0] idx_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] fpos_q, fpos_d;
    logic             ready_q, busy_q, done_q, found_q;
    logic [CNT_W-1:0] match_count_q, first_pos_q;

    logic accept;
    logic last_bit;
    logic det_z;

    assign accept   = start & ready_q;
    assign last_bit = (idx_q == CNT_W'(WIDTH - 1));

    // Serial bit is forced low outside SHIFT so the detector sees nothing.
    assign w = busy_q & shreg_q[WIDTH-1];
    assign z = det_z;

    pair_detect_core u_det (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (busy_q),
        .w   (w),
        .z   (det_z)
    );

    always_comb begin
        cnt_d  = cnt_q + CNT_W'(det_z);
        fpos_d = fpos_q;
        if (det_z && (cnt_q == '0))
            fpos_d = idx_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            shreg_q       <= '0;
            idx_q         <= '0;
            cnt_q         <= '0;
            fpos_q        <= '0;
            ready_q       <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            found_q       <= 1'b0;
            match_count_q <= '0;
            first_pos_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        shreg_q <= data_in;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        fpos_q  <= '0;
                        state_q <= ST_SHIFT;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
                    idx_q   <= idx_q + 1'b1;
                    cnt_q   <= cnt_d;
                    fpos_q  <= fpos_d;
                    if (last_bit) begin
                        // Visible results change only here and hold until the next completion.
                        state_q       <= ST_DONE;
                        ready_q       <= 1'b1;
                        busy_q        <= 1'b0;
                        done_q        <= 1'b1;
                        found_q       <= (cnt_d != '0);
                        match_count_q <= cnt_d;
                        first_pos_q   <= fpos_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready       = ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign found       = found_q;
    assign match_count = match_count_q;
    assign first_pos   = first_pos_q;

endmodule

// File: tb/tb_serial_pair_scan_ctrl.sv
// Directed bench for serial_pair_scan_ctrl: table of scans plus hand-written
// sequences for back-to-back starts, mid-scan reset and result holding.
module tb_serial_pair_scan_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             ready, busy, w, z, done, found;
    logic [CNT_W-1:0] match_count, first_pos;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_pair_scan_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .data_in     (data_in),
        .ready       (ready),
        .busy        (busy),
        .w           (w),
        .z           (z),
        .done        (done),
        .found       (found),
        .match_count (match_count),
        .first_pos   (first_pos)
    );

    typedef struct {
        logic [WIDTH-1:0] d;
        int               cnt;
        int               fpos;
        logic             fnd;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Run one scan; checks serial w/z against a bit model, latency, busy length,
    // and (hold >= 0) that match_count keeps its old value during SHIFT.
    task automatic do_scan(input logic [WIDTH-1:0] d, input int hold);
        int   lat;
        int   busy_n;
        int   bi;
        logic prev;
        logic ew;
        lat = 0; busy_n = 0; prev = 1'b0;
        @(negedge clk);
        start = 1'b1; data_in = d;
        @(posedge clk);
        #1 start = 1'b0; data_in = ~d;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (busy) begin
                busy_n++;
                bi = WIDTH - k;
                ew = (bi >= 0) ? d[bi] : 1'b0;
                check("serial_w", int'(w), int'(ew));
                check("serial_z", int'(z), int'(ew & prev));
                if (hold >= 0) check("hold_count", int'(match_count), hold);
                prev = ew;
            end
        end
        check("done_latency", lat, WIDTH + 1);
        check("busy_cycles", busy_n, WIDTH);
        check("ready_at_done", int'(ready), 1);
    endtask

    initial begin
        int first_done, second_done, dones, prev_cnt;

        vecs[0] = '{8'b0110_0000, 1, 2, 1'b1};
        vecs[1] = '{8'hFF,        7, 1, 1'b1};
        vecs[2] = '{8'b1010_1010, 0, 0, 1'b0};
        vecs[3] = '{8'b0000_0011, 1, 7, 1'b1};
        vecs[4] = '{8'b0101_0101, 0, 0, 1'b0};
        vecs[5] = '{8'b1111_0000, 3, 1, 1'b1};

        rst = 1'b1; start = 1'b0; data_in = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", int'(ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_found", int'(found), 0);
        check("rst_count", int'(match_count), 0);
        check("rst_fpos", int'(first_pos), 0);
        check("rst_w", int'(w), 0);
        check("rst_z", int'(z), 0);

        prev_cnt = 0;
        foreach (vecs[i]) begin
            do_scan(vecs[i].d, prev_cnt);
            check("tbl_count", int'(match_count), vecs[i].cnt);
            check("tbl_fpos", int'(first_pos), vecs[i].fpos);
            check("tbl_found", int'(found), int'(vecs[i].fnd));
            prev_cnt = vecs[i].cnt;
        end

        // Previous result is 3; a zero word keeps it through SHIFT, then clears it.
        do_scan(8'h00, 3);
        check("zero_count", int'(match_count), 0);
        check("zero_found", int'(found), 0);
        check("zero_fpos", int'(first_pos), 0);

        // Back-to-back: start held high, data changed mid-busy, captured in DONE.
        first_done = 0; second_done = 0;
        @(negedge clk);
        start = 1'b1; data_in = 8'b0000_0001;
        @(posedge clk);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 3) data_in = 8'b1000_0011;
            if (k == 10) start = 1'b0;
            if (done && first_done == 0) begin
                first_done = k;
                check("b2b_first_count", int'(match_count), 0);
                check("b2b_first_found", int'(found), 0);
            end else if (done && second_done == 0) begin
                second_done = k;
                check("b2b_second_count", int'(match_count), 1);
                check("b2b_second_fpos", int'(first_pos), 7);
                check("b2b_second_found", int'(found), 1);
            end
        end
        check("b2b_first_latency", first_done, WIDTH + 1);
        check("b2b_done_spacing", second_done - first_done, WIDTH + 1);

        // Reset during the 4th SHIFT cycle of 8'hFF aborts without a done pulse.
        @(negedge clk);
        start = 1'b1; data_in = 8'hFF;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 4; k++) @(negedge clk);
        check("abort_busy_before", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_ready", int'(ready), 1);
        check("abort_count", int'(match_count), 0);
        check("abort_found", int'(found), 0);
        check("abort_fpos", int'(first_pos), 0);
        check("abort_w", int'(w), 0);
        dones = int'(done);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            dones += int'(done);
        end
        check("abort_no_done", dones, 0);

        // A fresh scan after abort starts from a clean detector.
        do_scan(8'b1100_0000, 0);
        check("post_abort_count", int'(match_count), 1);
        check("post_abort_fpos", int'(first_pos), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
